// File: rtl/skdecode_seq_ctrl.sv
// skdecode_seq_ctrl: sequences s1/s2/t0 source reads and the delayed decoded-data writes.
module skdecode_seq_ctrl #(
  parameter int MAX_L      = 7,
  parameter int MAX_K      = 8,
  parameter int RD_ETA2    = 12,
  parameter int RD_ETA4    = 16,
  parameter int RD_T0      = 52,
  parameter int RD_LAT     = 1,
  parameter int ADDR_W     = 12,
  parameter int WR_BASE_S1 = 0,
  parameter int WR_BASE_S2 = 512,
  parameter int WR_BASE_T0 = 1024,
  parameter int WR_STRIDE  = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              zeroize,
  input  logic              start,
  input  logic [3:0]        mode_l,
  input  logic [3:0]        mode_k,
  input  logic              eta4,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        rd_state,
  output logic [2:0]        wr_state,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE = 3'd0, STAGE = 3'd1, S1 = 3'd2, S2 = 3'd3, T0 = 3'd4} state_t;
  localparam int WMAX = RD_T0 > RD_ETA4 ? (RD_T0 > RD_ETA2 ? RD_T0 : RD_ETA2)
                                        : (RD_ETA4 > RD_ETA2 ? RD_ETA4 : RD_ETA2);
  localparam int WW = $clog2(WMAX + 1);
  state_t st, st_nx;
  logic [3:0] l_q, k_q, poly, np;
  logic e4_q, bsy, dn, er, go, bad, lw, lp, seg_end, fin;
  logic [WW-1:0] word, nw;
  logic [ADDR_W-1:0] ra, base;
  // Read-side tags travel RD_LAT stages so each write knows its segment, poly and word.
  state_t st_p [RD_LAT];
  logic [3:0] poly_p [RD_LAT];
  logic [WW-1:0] word_p [RD_LAT];
  logic [RD_LAT-1:0] v_p, l_p;
  assign go = start && !bsy && st == IDLE;
  assign bad = mode_l == 4'd0 || int'(mode_l) > MAX_L || mode_k == 4'd0 || int'(mode_k) > MAX_K;
  assign rd_en = (st == S1 || st == S2 || st == T0) && !stall;
  assign nw = st == T0 ? WW'(RD_T0) : e4_q ? WW'(RD_ETA4) : WW'(RD_ETA2);
  assign np = st == S1 ? l_q : k_q;
  assign lw = word == nw - 1'b1;
  assign lp = poly == np - 4'd1;
  assign seg_end = rd_en && lw && lp;
  assign fin = v_p[RD_LAT-1] && l_p[RD_LAT-1];
  always_comb begin
    st_nx = st;
    if (st == IDLE && go && !bad) st_nx = STAGE;
    else if (st == STAGE) st_nx = S1;
    else if (seg_end) st_nx = st == S1 ? S2 : st == S2 ? T0 : IDLE;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st <= IDLE; l_q <= '0; k_q <= '0; e4_q <= 1'b0; ra <= '0; word <= '0; poly <= '0;
      bsy <= 1'b0; dn <= 1'b0; er <= 1'b0;
    end else if (zeroize) begin
      st <= IDLE; l_q <= '0; k_q <= '0; e4_q <= 1'b0; ra <= '0; word <= '0; poly <= '0;
      bsy <= 1'b0; dn <= 1'b0; er <= 1'b0;
    end else begin
      st <= st_nx;
      if (go && !bad) begin
        l_q <= mode_l; k_q <= mode_k; e4_q <= eta4; ra <= '0; word <= '0; poly <= '0;
      end else if (rd_en) begin
        ra <= ra + 1'b1;
        word <= lw ? '0 : word + 1'b1;
        poly <= lw ? (lp ? 4'd0 : poly + 4'd1) : poly;
      end
      bsy <= (go && !bad) || (bsy && !fin);
      dn <= fin;
      er <= go && bad;
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v_p <= '0; l_p <= '0;
      for (int i = 0; i < RD_LAT; i++) begin st_p[i] <= IDLE; poly_p[i] <= '0; word_p[i] <= '0; end
    end else if (zeroize) begin
      v_p <= '0; l_p <= '0;
      for (int i = 0; i < RD_LAT; i++) begin st_p[i] <= IDLE; poly_p[i] <= '0; word_p[i] <= '0; end
    end else begin
      v_p[0] <= rd_en; l_p[0] <= seg_end && st == T0;
      st_p[0] <= st; poly_p[0] <= poly; word_p[0] <= word;
      for (int i = 1; i < RD_LAT; i++) begin
        v_p[i] <= v_p[i-1]; l_p[i] <= l_p[i-1];
        st_p[i] <= st_p[i-1]; poly_p[i] <= poly_p[i-1]; word_p[i] <= word_p[i-1];
      end
    end
  end
  assign base = st_p[RD_LAT-1] == S1 ? ADDR_W'(WR_BASE_S1) :
                st_p[RD_LAT-1] == S2 ? ADDR_W'(WR_BASE_S2) : ADDR_W'(WR_BASE_T0);
  assign wr_en = v_p[RD_LAT-1];
  assign wr_addr = wr_en ? base + ADDR_W'(poly_p[RD_LAT-1]) * ADDR_W'(WR_STRIDE)
                              + ADDR_W'(word_p[RD_LAT-1]) : '0;
  assign wr_state = st_p[RD_LAT-1];
  assign rd_state = st;
  assign rd_addr = ra;
  assign busy = bsy;
  assign done = dn;
  assign error = er;
endmodule

// File: tb/tb_skdecode_seq_ctrl.sv
// tb_skdecode_seq_ctrl: directed runs against default and RD_LAT=3 instances.
module tb_skdecode_seq_ctrl;
  logic clk = 0, rst_b = 0, zeroize = 0, start = 0, eta4 = 0, stall = 0;
  logic [3:0] mode_l = 4'd4, mode_k = 4'd4;
  logic rd_en, wr_en, busy, done, error, rd_en3, wr_en3, busy3, done3, error3;
  logic [11:0] rd_addr, wr_addr, rd_addr3, wr_addr3;
  logic [2:0] rd_state, wr_state, rd_state3, wr_state3;
  skdecode_seq_ctrl dut (.clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start(start),
    .mode_l(mode_l), .mode_k(mode_k), .eta4(eta4), .stall(stall), .rd_en(rd_en),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .rd_state(rd_state),
    .wr_state(wr_state), .busy(busy), .done(done), .error(error));
  skdecode_seq_ctrl #(.RD_LAT(3)) dut3 (.clk(clk), .rst_b(rst_b), .zeroize(zeroize),
    .start(start), .mode_l(mode_l), .mode_k(mode_k), .eta4(eta4), .stall(stall),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .rd_state(rd_state3), .wr_state(wr_state3), .busy(busy3), .done(done3), .error(error3));
  always #5 clk = ~clk;
  int cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;
  int checks = 0, failures = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  int t0 = 0, c, rd_n, rd_first, rd_last, last_rd_c, max_gap, bad_addr, first_ra;
  int wr_n, wr_first, wr_last, last_wa, done_c, done_n, err_c, err_n, busy_seen, busy_done;
  int st1, busy1, wr3_first, wr3_pre, wr3_post, zc;
  int cnt_s [8];
  int fwa [8];
  task automatic clr();
    rd_n = 0; rd_first = -1; rd_last = -1; last_rd_c = 0; max_gap = 0; bad_addr = 0; first_ra = -1;
    wr_n = 0; wr_first = -1; wr_last = -1; last_wa = -1; done_c = -1; done_n = 0; err_c = -1;
    err_n = 0; busy_seen = 0; busy_done = -1; st1 = -1; busy1 = -1;
    wr3_first = -1; wr3_pre = 0; wr3_post = 0; zc = 1000000000;
    for (int i = 0; i < 8; i++) begin cnt_s[i] = 0; fwa[i] = -1; end
  endtask
  always @(negedge clk) begin
    c = cyc_abs - t0;
    if (c == 1) begin st1 = int'(rd_state); busy1 = int'(busy); end
    if (busy) busy_seen = 1;
    if (rd_en) begin
      if (rd_n == 0) begin rd_first = c; first_ra = int'(rd_addr); end
      else if (c - last_rd_c - 1 > max_gap) max_gap = c - last_rd_c - 1;
      if (int'(rd_addr) != rd_n) bad_addr++;
      cnt_s[rd_state]++; rd_n++; last_rd_c = c; rd_last = c;
    end
    if (wr_en) begin
      if (wr_n == 0) wr_first = c;
      if (fwa[wr_state] < 0) fwa[wr_state] = int'(wr_addr);
      last_wa = int'(wr_addr); wr_n++; wr_last = c;
    end
    if (done) begin
      if (done_c < 0) done_c = c;
      done_n++; busy_done = int'(busy);
    end
    if (error) begin
      if (err_c < 0) err_c = c;
      err_n++;
    end
    if (wr_en3) begin
      if (wr3_first < 0) wr3_first = c;
      if (c > zc) wr3_post++; else wr3_pre++;
    end
  end
  task automatic start_run(input logic [3:0] l, input logic [3:0] k, input logic e);
    repeat (4) @(posedge clk);
    #1 clr(); t0 = cyc_abs;
    mode_l = l; mode_k = k; eta4 = e; start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic to_cycle(input int n);
    while (cyc_abs - t0 < n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 2000 && done_c < 0; i++) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [3:0] l, input logic [3:0] k);
    mode_l = l; mode_k = k; start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 check("rst_addr", int'({rd_addr, wr_addr}), 0);
    check("rst_ctl", int'({rd_en, wr_en, rd_state, wr_state, busy, done, error}), 0);
    rst_b = 1;
    start_run(4'd4, 4'd4, 1'b0);
    wait_done();
    check("t1_stage_state", st1, 1);
    check("t1_stage_busy", busy1, 1);
    check("t1_rd_first", rd_first, 2);
    check("t1_rd_last", rd_last, 305);
    check("t1_rd_n", rd_n, 304);
    check("t1_rd_addr_seq", bad_addr, 0);
    check("t1_wr_first", wr_first, 3);
    check("t1_wr_last", wr_last, 306);
    check("t1_done_c", done_c, 307);
    check("t1_busy_at_done", busy_done, 0);
    check("t1_s2_wa", fwa[3], 512);
    check("t1_last_wa", last_wa, 1267);
    check("t1_lat3_wr_first", wr3_first, 5);
    check("t1_idle", int'({rd_state, wr_state, busy, done}), 0);
    check("t1_done_n", done_n, 1);
    start_run(4'd7, 4'd8, 1'b1);
    to_cycle(40);
    pulse_start(4'd1, 4'd1);
    to_cycle(200);
    pulse_start(4'd0, 4'd4);
    wait_done();
    check("t2_s1_n", cnt_s[2], 112);
    check("t2_s2_n", cnt_s[3], 128);
    check("t2_t0_n", cnt_s[4], 416);
    check("t2_rd_n", rd_n, 656);
    check("t2_s1_wa", fwa[2], 0);
    check("t2_s2_wa", fwa[3], 512);
    check("t2_t0_wa", fwa[4], 1024);
    check("t2_last_wa", last_wa, 1523);
    check("t2_done_c", done_c, 659);
    check("t2_no_err", err_c, -1);
    check("t2_done_n", done_n, 1);
    start_run(4'd4, 4'd4, 1'b0);
    to_cycle(60);
    stall = 1;
    repeat (5) @(posedge clk);
    #1 stall = 0;
    wait_done();
    check("t3_gap", max_gap, 5);
    check("t3_rd_n", rd_n, 304);
    check("t3_rd_addr_seq", bad_addr, 0);
    check("t3_rd_last", rd_last, 310);
    check("t3_done_c", done_c, 312);
    start_run(4'd0, 4'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("t4a_err_c", err_c, 1);
    check("t4a_err_n", err_n, 1);
    check("t4a_rd_n", rd_n, 0);
    check("t4a_busy", busy_seen, 0);
    start_run(4'd4, 4'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("t4b_err_c", err_c, 1);
    check("t4b_rd_n", rd_n, 0);
    check("t4b_busy", busy_seen, 0);
    start_run(4'd4, 4'd4, 1'b0);
    to_cycle(150);
    check("t5_in_t0", int'(rd_state), 4);
    rst_b = 0;
    #1 check("t5_rst_addr", int'({rd_addr, wr_addr}), 0);
    check("t5_rst_ctl", int'({rd_en, wr_en, rd_state, wr_state, busy, done, error}), 0);
    @(posedge clk); #1 rst_b = 1;
    start_run(4'd4, 4'd4, 1'b0);
    wait_done();
    check("t5_first_ra", first_ra, 0);
    check("t5_rd_n", rd_n, 304);
    check("t5_done_c", done_c, 307);
    start_run(4'd4, 4'd4, 1'b0);
    to_cycle(20);
    zc = 20; zeroize = 1;
    @(posedge clk); #1 zeroize = 0;
    check("t6_lat3_states", int'({rd_state3, wr_state3, busy3}), 0);
    check("t6_states", int'({rd_state, wr_state, busy}), 0);
    to_cycle(40);
    check("t6_lat3_wr_pre", wr3_pre, 16);
    check("t6_lat3_wr_post", wr3_post, 0);
    check("t6_rd_n", rd_n, 19);
    check("t6_done_n", done_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/skdecode_seq_ctrl.md
SKDECODE_SEQ_CTRL -- requirements
Module: skdecode_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_L, default 7, maximum s1 polynomial count.
REQ-002 SHALL have parameter MAX_K, default 8, maximum s2/t0 polynomial count.
REQ-003 SHALL have parameter RD_ETA2, default 12, read words per s1/s2 polynomial when eta=2.
REQ-004 SHALL have parameter RD_ETA4, default 16, read words per s1/s2 polynomial when eta=4.
REQ-005 SHALL have parameter RD_T0, default 52, read words per t0 polynomial.
REQ-006 SHALL have parameter RD_LAT, default 1, source-memory read latency in cycles, range 1-4.
REQ-007 SHALL have parameter ADDR_W, default 12, width of the read and write address ports.
REQ-008 SHALL have parameters WR_BASE_S1, WR_BASE_S2, WR_BASE_T0 and WR_STRIDE, defaults 0, 512, 1024 and 64, for write-side address generation.
REQ-009 SHALL have port clk, input, 1, the single clock.
REQ-010 SHALL have port rst_b, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port zeroize, input, 1, synchronous clear.
REQ-012 SHALL have port start, input, 1, single-cycle run request.
REQ-013 SHALL have port mode_l, input, 4, s1 polynomial count for the run.
REQ-014 SHALL have port mode_k, input, 4, s2 and t0 polynomial count for the run.
REQ-015 SHALL have port eta4, input, 1, eta select (1 = eta 4, 0 = eta 2).
REQ-016 SHALL have port stall, input, 1, downstream backpressure that blocks new reads.
REQ-017 SHALL have port rd_en, output, 1, source read strobe.
REQ-018 SHALL have port rd_addr, output, ADDR_W, source read address.
REQ-019 SHALL have port wr_en, output, 1, decoded-data write strobe.
REQ-020 SHALL have port wr_addr, output, ADDR_W, destination write address.
REQ-021 SHALL have port rd_state, output, 3, read FSM state.
REQ-022 SHALL have port wr_state, output, 3, write FSM state.
REQ-023 SHALL have port busy, output, 1, run in progress.
REQ-024 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-025 SHALL have port error, output, 1, one-cycle rejected-config pulse.

Function
REQ-026 SHALL encode both FSMs as IDLE=0, STAGE=1, S1=2, S2=3, T0=4.
REQ-027 SHALL, on start in IDLE, check the config and reject it when mode_l is 0 or greater than MAX_L, or mode_k is 0 or greater than MAX_K: error pulses the next cycle and both FSMs stay in IDLE.
REQ-028 SHALL, on start with a valid config, latch mode_l, mode_k and eta4; the read FSM goes IDLE->STAGE for one cycle, then to S1, and busy rises in the STAGE cycle.
REQ-029 SHALL, in S1/S2/T0, assert rd_en every cycle stall is low; while stall is high, rd_en=0 and all read counters hold.
REQ-030 SHALL set words per polynomial to RD_ETA4 if eta4 else RD_ETA2 in S1/S2, and to RD_T0 in T0.
REQ-031 SHALL use a word counter that wraps to 0 after the last word of each polynomial and increments the polynomial counter.
REQ-032 SHALL, after the last word of the last polynomial, move S1->S2, S2->T0 and T0->IDLE, resetting the polynomial counter at each transition.
REQ-033 SHALL start rd_addr at 0 and increment it by 1 per rd_en, contiguously across S1, S2 and T0.
REQ-034 SHALL assert wr_en exactly RD_LAT cycles after each rd_en, carrying a delayed segment, polynomial and word tag; writes in flight SHALL complete regardless of stall.
REQ-035 SHALL compute wr_addr = segment base (WR_BASE_S1/S2/T0) + poly*WR_STRIDE + word, truncated to ADDR_W.
REQ-036 SHALL have the write FSM mirror the read FSM delayed by RD_LAT cycles, returning to IDLE after the final write.
REQ-037 SHALL pulse done on the cycle after the final wr_en and drop busy on that same cycle.
REQ-038 SHALL ignore start while busy.
REQ-039 SHALL treat start and a final-write cycle occurring together as busy, so that start is ignored.

Reset
REQ-040 SHALL, on rst_b low at any time including mid-run, clear all FSMs, counters, pipeline tags and latched config asynchronously, and drive every output to 0.
REQ-041 SHALL, on zeroize high, apply the same clearing as reset synchronously on the next edge, with priority over start and stall; in-flight writes are discarded.

Verification
REQ-042 SHALL cover: defaults, L=4, K=4, eta4=0, start at cycle 0 -> rd_en cycles 2-305 (304 reads), rd_addr 0-303, wr_en cycles 3-306, done at cycle 307.
REQ-043 SHALL cover: eta4=1, L=7, K=8 -> 112 S1 reads, 128 S2 reads, 416 T0 reads; first S2 wr_addr=512, first T0 wr_addr=1024.
REQ-044 SHALL cover: stall high for 5 cycles mid-S2 -> exactly 5-cycle gap in rd_en, total reads unchanged, done delayed 5 cycles.
REQ-045 SHALL cover: mode_l=0 or mode_k=9 -> error pulse at cycle 1, no rd_en, busy stays 0.
REQ-046 SHALL cover: rst_b low during T0, then start -> all outputs 0 immediately on reset; the new run restarts at rd_addr 0.
REQ-047 SHALL cover: RD_LAT=3 and zeroize mid-S1 -> no wr_en after the zeroize edge, both states return to 0.
